// File: rtl/expr_tx.sv
// Streams a loaded expression as ASCII digits and '+'/'*' operators, one char per
// accepted cycle, and evaluates it with '*' binding tighter than '+'.
module expr_tx #(
    parameter int N_OPS = 4,
    parameter int W_RES = 16
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 start,
    input  logic [4*N_OPS-1:0]   operands,
    input  logic [N_OPS-2:0]     ops,
    input  logic                 ready,
    output logic [7:0]           out,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 done,
    output logic [W_RES-1:0]     result
);
    // state    | meaning
    // S_IDLE   | waiting for start
    // S_DIGIT  | presenting operand idx
    // S_OP     | presenting operator between operand idx and idx+1
    // S_FINISH | done pulse, result just loaded
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DIGIT  = 2'd1;
    localparam logic [1:0] S_OP     = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;
    localparam int IW = $clog2(N_OPS);

    logic [1:0]       state;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    idx_nxt;
    logic [3:0]       dig [N_OPS];
    logic [N_OPS-2:0] ops_q;
    logic [W_RES-1:0] sum, term, sum_nxt, term_nxt, d_ext;
    logic [3:0]       d_cur;
    logic             accept;

    function automatic logic [3:0] sat(input logic [3:0] v);
        return (v > 4'd9) ? 4'd9 : v;
    endfunction

    function automatic logic [7:0] digit_char(input logic [3:0] v);
        return 8'h30 + {4'h0, v};
    endfunction

    assign accept  = out_valid & ready;
    assign idx_nxt = idx + IW'(1);
    assign d_cur   = dig[idx];
    assign d_ext   = {{(W_RES-4){1'b0}}, d_cur};

    // Running evaluation applied when the current digit is accepted.
    always_comb begin
        sum_nxt  = sum;
        term_nxt = term;
        if (idx == '0) begin
            sum_nxt  = '0;
            term_nxt = d_ext;
        end else if (ops_q[idx - IW'(1)]) begin
            term_nxt = term * d_ext;
        end else begin
            sum_nxt  = sum + term;
            term_nxt = d_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state     <= S_IDLE;
            idx       <= '0;
            ops_q     <= '0;
            sum       <= '0;
            term      <= '0;
            out       <= 8'h00;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            for (int i = 0; i < N_OPS; i++) dig[i] <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < N_OPS; i++) dig[i] <= sat(operands[4*i +: 4]);
                        ops_q     <= ops;
                        idx       <= '0;
                        out       <= digit_char(sat(operands[3:0]));
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_DIGIT;
                    end
                end
                S_DIGIT: begin
                    if (accept) begin
                        sum  <= sum_nxt;
                        term <= term_nxt;
                        if (idx == IW'(N_OPS-1)) begin
                            out       <= 8'h00;
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            result    <= sum_nxt + term_nxt;
                            state     <= S_FINISH;
                        end else begin
                            out   <= ops_q[idx] ? 8'h2A : 8'h2B;
                            state <= S_OP;
                        end
                    end
                end
                S_OP: begin
                    if (accept) begin
                        idx   <= idx_nxt;
                        out   <= digit_char(dig[idx_nxt]);
                        state <= S_DIGIT;
                    end
                end
                S_FINISH: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_expr_tx.sv
// Directed bench for expr_tx: streams, back-pressure, saturation, ignored start, reset.
module tb_expr_tx;
    logic        clk = 1'b0;
    logic        clr, start, ready;
    logic [15:0] operands;
    logic [2:0]  ops;
    logic [7:0]  out, out8;
    logic        out_valid, busy, done, out_valid8, busy8, done8;
    logic [15:0] result;
    logic [7:0]  result8;
    int checks = 0;
    int errors = 0;

    expr_tx #(.N_OPS(4), .W_RES(16)) dut (
        .clk(clk), .clr(clr), .start(start), .operands(operands), .ops(ops),
        .ready(ready), .out(out), .out_valid(out_valid), .busy(busy),
        .done(done), .result(result));

    expr_tx #(.N_OPS(4), .W_RES(8)) dut8 (
        .clk(clk), .clr(clr), .start(start), .operands(operands), .ops(ops),
        .ready(ready), .out(out8), .out_valid(out_valid8), .busy(busy8),
        .done(done8), .result(result8));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one stream from the current operands/ops; inputs change on negedges.
    task automatic stream(input logic [55:0] chars, input bit toggle,
                          input logic [15:0] exp_res, input logic [7:0] exp_res8,
                          input int pulse_at);
        logic [55:0] s;
        int n;
        int cyc;
        s = chars;
        n = 0;
        cyc = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (n < 7 && cyc < 100) begin
            ready = toggle ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
            if (n == pulse_at) begin
                start    = 1'b1;
                operands = 16'h5555;
                ops      = 3'b111;
            end else begin
                start = 1'b0;
            end
            chk("valid", {31'd0, out_valid}, 32'd1);
            chk("char", {24'd0, out}, {24'd0, s[55-8*n -: 8]});
            chk("busy", {31'd0, busy}, 32'd1);
            if (out_valid && ready) n++;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        ready = 1'b1;
        chk("all_chars", n, 7);
        chk("done", {31'd0, done}, 32'd1);
        chk("valid_fin", {31'd0, out_valid}, 32'd0);
        chk("out_fin", {24'd0, out}, 32'd0);
        chk("result", {16'd0, result}, {16'd0, exp_res});
        chk("result8", {24'd0, result8}, {24'd0, exp_res8});
        @(negedge clk);
        chk("done_drop", {31'd0, done}, 32'd0);
        chk("busy_drop", {31'd0, busy}, 32'd0);
        chk("result_hold", {16'd0, result}, {16'd0, exp_res});
        repeat (2) @(negedge clk);
    endtask

    initial begin
        clr = 1'b0; start = 1'b0; ready = 1'b1; operands = 16'h0; ops = 3'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out", {24'd0, out}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", {16'd0, result}, 32'd0);
        clr = 1'b1;

        // 1+2+3*4 = 15, full-rate
        operands = 16'h4321; ops = 3'b100;
        stream("1+2+3*4", 1'b0, 16'd15, 8'd15, -1);

        // same load, ready 1,0,0,1 pattern
        operands = 16'h4321; ops = 3'b100;
        stream("1+2+3*4", 1'b1, 16'd15, 8'd15, -1);

        // 9*9*9*9 = 6561; mod 256 = 161
        operands = 16'h9999; ops = 3'b111;
        stream("9*9*9*9", 1'b0, 16'd6561, 8'd161, -1);

        // saturation: C+1+1+1 -> 9+1+1+1 = 12
        operands = 16'h111C; ops = 3'b000;
        stream("9+1+1+1", 1'b0, 16'd12, 8'd12, -1);

        // start pulsed with new data during the 3rd char is ignored
        operands = 16'h4321; ops = 3'b100;
        stream("1+2+3*4", 1'b0, 16'd15, 8'd15, 2);

        // reset during the 4th char
        operands = 16'h4321; ops = 3'b100; ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_char", {24'd0, out}, 32'h2B);
        clr = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        chk("abort_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_result", {16'd0, result}, 32'd0);
        chk("abort_out", {24'd0, out}, 32'd0);
        repeat (3) @(negedge clk);
        chk("abort_no_resume", {31'd0, out_valid}, 32'd0);

        // fresh stream after abort: 2*3+0+5 = 11
        operands = 16'h5032; ops = 3'b001;
        stream("2*3+0+5", 1'b0, 16'd11, 8'd11, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
